// File: rtl/change_dispenser.sv
// Coin payout engine: pays a refund greedily from Rs5/Rs2/Rs1 hoppers with per-hopper inventory.
// Optional feature macro CHANGE_AUDIT_EN adds a running paid_total output.
module change_dispenser #(
  parameter int AMT_W        = 7,
  parameter int CNT_W        = 8,
  parameter int INIT_COUNT   = 20,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int LOW_THRESH   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refund_valid,
  input  logic [AMT_W-1:0] refund_amt,
  output logic             ready,
  output logic             eject_5,
  output logic             eject_2,
  output logic             eject_1,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  input  logic             reload,
  input  logic [1:0]       reload_sel,
  input  logic [CNT_W-1:0] reload_cnt,
  output logic [2:0]       hopper_low
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0]      paid_total
`endif
);

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       coin_q, coin_d;       // one-hot {Rs5,Rs2,Rs1}
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt5_q, cnt5_d, cnt2_q, cnt2_d, cnt1_q, cnt1_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [2:0]       eject_q, eject_d;
`ifdef CHANGE_AUDIT_EN
  logic [15:0]      paid_q, paid_d;
`endif

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coin_d      = coin_q;
    timer_d     = timer_q;
    cnt5_d      = cnt5_q;
    cnt2_d      = cnt2_q;
    cnt1_d      = cnt1_q;
    shortfall_d = shortfall_q;
`ifdef CHANGE_AUDIT_EN
    paid_d      = paid_q;
`endif

    case (state_q)
      IDLE: begin
        if (refund_valid) begin
          rem_d       = refund_amt;
          shortfall_d = {AMT_W{1'b0}};
          state_d     = SELECT;
        end else begin
          state_d = IDLE;
        end
        // Reload is honoured in IDLE even when an accept happens in the same cycle.
        if (reload) begin
          case (reload_sel)
            2'b00:   cnt1_d = sat_add(cnt1_q, reload_cnt);
            2'b01:   cnt2_d = sat_add(cnt2_q, reload_cnt);
            2'b10:   cnt5_d = sat_add(cnt5_q, reload_cnt);
            default: cnt1_d = cnt1_q;
          endcase
        end else begin
          cnt1_d = cnt1_q;
        end
      end
      SELECT: begin
        timer_d = TMR_W'(PULSE_CYCLES - 1);
        if (rem_q == {AMT_W{1'b0}}) begin
          state_d = DONE;
        end else if (rem_q >= AMT_W'(5) && cnt5_q != {CNT_W{1'b0}}) begin
          rem_d   = rem_q - AMT_W'(5);
          cnt5_d  = cnt5_q - CNT_W'(1);
          coin_d  = 3'b100;
          state_d = PULSE;
`ifdef CHANGE_AUDIT_EN
          paid_d  = paid_q + 16'd5;
`endif
        end else if (rem_q >= AMT_W'(2) && cnt2_q != {CNT_W{1'b0}}) begin
          rem_d   = rem_q - AMT_W'(2);
          cnt2_d  = cnt2_q - CNT_W'(1);
          coin_d  = 3'b010;
          state_d = PULSE;
`ifdef CHANGE_AUDIT_EN
          paid_d  = paid_q + 16'd2;
`endif
        end else if (cnt1_q != {CNT_W{1'b0}}) begin
          rem_d   = rem_q - AMT_W'(1);
          cnt1_d  = cnt1_q - CNT_W'(1);
          coin_d  = 3'b001;
          state_d = PULSE;
`ifdef CHANGE_AUDIT_EN
          paid_d  = paid_q + 16'd1;
`endif
        end else begin
          shortfall_d = rem_q;
          state_d     = DONE;
        end
      end
      PULSE: begin
        if (timer_q == {TMR_W{1'b0}}) begin
          timer_d = TMR_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (timer_q == {TMR_W{1'b0}}) begin
          state_d = SELECT;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
    if (state_d == PULSE) begin
      eject_d = coin_d;
    end else begin
      eject_d = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= {AMT_W{1'b0}};
      coin_q      <= 3'b000;
      timer_q     <= {TMR_W{1'b0}};
      cnt5_q      <= CNT_W'(INIT_COUNT);
      cnt2_q      <= CNT_W'(INIT_COUNT);
      cnt1_q      <= CNT_W'(INIT_COUNT);
      shortfall_q <= {AMT_W{1'b0}};
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      eject_q     <= 3'b000;
`ifdef CHANGE_AUDIT_EN
      paid_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      coin_q      <= coin_d;
      timer_q     <= timer_d;
      cnt5_q      <= cnt5_d;
      cnt2_q      <= cnt2_d;
      cnt1_q      <= cnt1_d;
      shortfall_q <= shortfall_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      eject_q     <= eject_d;
`ifdef CHANGE_AUDIT_EN
      paid_q      <= paid_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign shortfall = shortfall_q;
  assign eject_5   = eject_q[2];
  assign eject_2   = eject_q[1];
  assign eject_1   = eject_q[0];
  assign hopper_low = {cnt5_q <= CNT_W'(LOW_THRESH),
                       cnt2_q <= CNT_W'(LOW_THRESH),
                       cnt1_q <= CNT_W'(LOW_THRESH)};
`ifdef CHANGE_AUDIT_EN
  assign paid_total = paid_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: greedy-payout reference model with per-cycle expected traces.
module tb_change_dispenser;
  localparam int AMT_W = 7;
  localparam int CNT_W = 8;
  localparam int P = 2;
  localparam int G = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             refund_valid = 1'b0;
  logic [AMT_W-1:0] refund_amt = '0;
  logic             ready, eject_5, eject_2, eject_1, done;
  logic [AMT_W-1:0] shortfall;
  logic             reload = 1'b0;
  logic [1:0]       reload_sel = 2'b00;
  logic [CNT_W-1:0] reload_cnt = '0;
  logic [2:0]       hopper_low;
`ifdef CHANGE_AUDIT_EN
  logic [15:0]      paid_total;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt[3];   // model inventory: [0]=Rs1, [1]=Rs2, [2]=Rs5
  int m_paid = 0;

  change_dispenser dut (
    .clk(clk), .reset(reset), .refund_valid(refund_valid), .refund_amt(refund_amt),
    .ready(ready), .eject_5(eject_5), .eject_2(eject_2), .eject_1(eject_1), .done(done),
    .shortfall(shortfall), .reload(reload), .reload_sel(reload_sel), .reload_cnt(reload_cnt),
    .hopper_low(hopper_low)
`ifdef CHANGE_AUDIT_EN
    , .paid_total(paid_total)
`endif
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_reload(input int sel, input int cnt);
    case (sel)
      0: m_cnt[0] = sat(m_cnt[0] + cnt);
      1: m_cnt[1] = sat(m_cnt[1] + cnt);
      2: m_cnt[2] = sat(m_cnt[2] + cnt);
      default: ;
    endcase
  endfunction

  task automatic check_counts(input string name);
    logic [2:0] exp_low;
    exp_low = {m_cnt[2] <= 2, m_cnt[1] <= 2, m_cnt[0] <= 2};
    n_tests++;
    if (int'(dut.cnt5_q) !== m_cnt[2] || int'(dut.cnt2_q) !== m_cnt[1] || int'(dut.cnt1_q) !== m_cnt[0]) begin
      n_fail++;
      $display("FAIL %s counts: got Rs5=%0d Rs2=%0d Rs1=%0d, expected %0d %0d %0d", name,
               dut.cnt5_q, dut.cnt2_q, dut.cnt1_q, m_cnt[2], m_cnt[1], m_cnt[0]);
    end
    n_tests++;
    if (hopper_low !== exp_low) begin
      n_fail++;
      $display("FAIL %s hopper_low: got %b, expected %b", name, hopper_low, exp_low);
    end
`ifdef CHANGE_AUDIT_EN
    n_tests++;
    if (int'(paid_total) !== m_paid) begin
      n_fail++;
      $display("FAIL %s paid_total: got %0d, expected %0d", name, paid_total, m_paid);
    end
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    refund_valid = 1'b0;
    reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt[0] = 20; m_cnt[1] = 20; m_cnt[2] = 20;
    m_paid = 0;
  endtask

  task automatic do_reload(input int sel, input int cnt);
    reload = 1'b1;
    reload_sel = 2'(sel);
    reload_cnt = 8'(cnt);
    @(posedge clk); #1;
    reload = 1'b0;
    model_reload(sel, cnt);
  endtask

  // One payout: builds the expected {done,e5,e2,e1} timeline from the greedy rule and compares each cycle.
  task automatic run_payout(input string name, input int amt, input bit refire, input bit busy_reload,
                            input int acc_sel, input int acc_cnt);
    logic [3:0] exp_q[$];
    logic [3:0] obs;
    int rem, d, exp_short, bad_idx;
    logic [3:0] bad_obs, bad_exp;

    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b, expected 1", name, ready);
    end
    if (acc_sel >= 0) model_reload(acc_sel, acc_cnt);
    rem = amt;
    while (rem > 0) begin
      if (rem >= 5 && m_cnt[2] > 0) d = 5;
      else if (rem >= 2 && m_cnt[1] > 0) d = 2;
      else if (m_cnt[0] > 0) d = 1;
      else break;
      rem -= d;
      m_paid = (m_paid + d) % 65536;
      exp_q.push_back(4'b0000);
      for (int i = 0; i < P; i++)
        exp_q.push_back(d == 5 ? 4'b0100 : (d == 2 ? 4'b0010 : 4'b0001));
      for (int i = 0; i < G; i++) exp_q.push_back(4'b0000);
      if (d == 5) m_cnt[2]--; else if (d == 2) m_cnt[1]--; else m_cnt[0]--;
    end
    exp_short = rem;
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1000);

    refund_valid = 1'b1;
    refund_amt = 7'(amt);
    if (acc_sel >= 0) begin
      reload = 1'b1; reload_sel = 2'(acc_sel); reload_cnt = 8'(acc_cnt);
    end
    @(posedge clk); #1;
    reload = 1'b0;
    if (!refire) refund_valid = 1'b0;
    else refund_amt = 7'($urandom_range(1, 15));
    bad_idx = -1; bad_obs = '0; bad_exp = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (busy_reload && i == 1) begin
        reload = 1'b1; reload_sel = 2'b00; reload_cnt = 8'd10;
      end else begin
        reload = 1'b0;
      end
      obs = {done, eject_5, eject_2, eject_1};
      if (obs !== exp_q[i] && bad_idx < 0) begin
        bad_idx = i; bad_obs = obs; bad_exp = exp_q[i];
      end
      if (i == exp_q.size() - 1) begin
        refund_valid = 1'b0;
        n_tests++;
        if (int'(shortfall) !== exp_short) begin
          n_fail++;
          $display("FAIL %s shortfall: got %0d, expected %0d", name, shortfall, exp_short);
        end
      end
    end
    reload = 1'b0;
    n_tests++;
    if (bad_idx >= 0) begin
      n_fail++;
      $display("FAIL %s trace: cycle %0d got {done,e5,e2,e1}=%b, expected %b", name, bad_idx, bad_obs, bad_exp);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b ready=%b, expected done=0 ready=1", name, done, ready);
    end
    check_counts(name);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (ready !== 1'b1 || {eject_5, eject_2, eject_1} !== 3'b000 || done !== 1'b0 || shortfall !== 7'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got ready=%b ej=%b done=%b short=%0d, expected 1 000 0 0",
               ready, {eject_5, eject_2, eject_1}, done, shortfall);
    end
    check_counts("reset");
  endtask

  task automatic test_basic();
    do_reset();
    run_payout("amt7", 7, 1'b0, 1'b0, -1, 0);
    run_payout("amt4", 4, 1'b0, 1'b0, -1, 0);
    run_payout("amt0", 0, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 2) == 0) do_reload($urandom_range(0, 3), $urandom_range(0, 40));
      run_payout("random", $urandom_range(0, 15), 1'b0, 1'b0, -1, 0);
    end
  endtask

  task automatic test_busy_refire();
    do_reset();
    run_payout("refire", 13, 1'b1, 1'b0, -1, 0);
  endtask

  task automatic test_drain();
    do_reset();
    while (m_cnt[2] > 0) run_payout("drain5", 5, 1'b0, 1'b0, -1, 0);
    while (m_cnt[0] > 0) run_payout("drain1", 1, 1'b0, 1'b0, -1, 0);
    run_payout("no_backtrack3", 3, 1'b0, 1'b0, -1, 0);
    run_payout("only_twos8", 8, 1'b0, 1'b0, -1, 0);
    while (m_cnt[1] > 0) run_payout("drain2", 2, 1'b0, 1'b0, -1, 0);
    run_payout("empty8", 8, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_reload();
    do_reset();
    do_reload(0, 250);
    check_counts("reload_sat");
    do_reload(3, 99);
    check_counts("reload_sel11");
    run_payout("busy_reload", 1, 1'b0, 1'b1, -1, 0);
    run_payout("accept_reload", 6, 1'b0, 1'b0, 1, 3);
  endtask

  task automatic test_mid_reset();
    int guard;
    bit saw_done;
    do_reset();
    refund_valid = 1'b1;
    refund_amt = 7'd5;
    @(posedge clk); #1;
    refund_valid = 1'b0;
    guard = 0;
    while (eject_5 !== 1'b1 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    n_tests++;
    if (eject_5 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset wait_eject5: got %b, expected 1 within 10 cycles", eject_5);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_cnt[0] = 20; m_cnt[1] = 20; m_cnt[2] = 20;
    m_paid = 0;
    n_tests++;
    if ({eject_5, eject_2, eject_1} !== 3'b000 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset outputs: got ej=%b done=%b ready=%b, expected 000 0 1",
               {eject_5, eject_2, eject_1}, done, ready);
    end
    check_counts("mid_reset");
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1 || {eject_5, eject_2, eject_1} !== 3'b000) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL mid_reset quiet: got activity after reset, expected none");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_busy_refire();
    test_drain();
    test_reload();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
